// File: rtl/whack_gfx_pkg.sv
// Shared definitions for the Whack graphics path: draw-mode encodings,
// default screen geometry and the rectangle engine's FSM state encoding.
package whack_gfx_pkg;

    localparam logic [1:0] MODE_FILL    = 2'b00;
    localparam logic [1:0] MODE_OUTLINE = 2'b01;
    localparam logic [1:0] MODE_CLEAR   = 2'b10;

    localparam int SCR_W_DEFAULT = 160;
    localparam int SCR_H_DEFAULT = 120;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_SCAN = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/rect_scan_counter.sv
// Row-major 2-D offset counter for the rectangle engine. It publishes the offset
// about to be emitted (zero on clear, else the successor of the current one).
module rect_scan_counter
    import whack_gfx_pkg::*;
#(
    parameter int SZ_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            step,
    input  logic [SZ_W-1:0] w,
    input  logic [SZ_W-1:0] h,
    output logic [SZ_W-1:0] tgt_cx,
    output logic [SZ_W-1:0] tgt_cy,
    output logic            at_left,
    output logic            at_right,
    output logic            at_top,
    output logic            at_bottom,
    output logic            last
);

    logic [SZ_W-1:0] cx;
    logic [SZ_W-1:0] cy;
    logic [SZ_W-1:0] w_max;
    logic [SZ_W-1:0] h_max;

    assign w_max = w - SZ_W'(1);
    assign h_max = h - SZ_W'(1);
    assign last  = (cx == w_max) && (cy == h_max);

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        tgt_cx = '0;
        tgt_cy = '0;
        if (!clear) begin
            if (cx == w_max) begin
                tgt_cy = cy + SZ_W'(1);
            end else begin
                tgt_cx = cx + SZ_W'(1);
                tgt_cy = cy;
            end
        end
    end

    assign at_left   = (tgt_cx == '0);
    assign at_right  = (tgt_cx == w_max);
    assign at_top    = (tgt_cy == '0);
    assign at_bottom = (tgt_cy == h_max);

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cx <= '0;
            cy <= '0;
        end else if (clear || step) begin
            cx <= tgt_cx;
            cy <= tgt_cy;
        end
    end

endmodule

// File: rtl/rect_plotter.sv
// Rectangle draw engine: one command per handshake, one candidate pixel per clock
// on a registered VGA pixel-plot port, with clipping and fill/outline/clear modes.
module rect_plotter
    import whack_gfx_pkg::*;
#(
    parameter int X_W   = 8,
    parameter int Y_W   = 7,
    parameter int C_W   = 3,
    parameter int SZ_W  = 5,
    parameter int SCR_W = SCR_W_DEFAULT,
    parameter int SCR_H = SCR_H_DEFAULT
) (
    input  logic            CLOCK_50,
    input  logic            Reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [X_W-1:0]  req_x,
    input  logic [Y_W-1:0]  req_y,
    input  logic [SZ_W-1:0] req_w,
    input  logic [SZ_W-1:0] req_h,
    input  logic [C_W-1:0]  req_color,
    input  logic [1:0]      req_mode,
    output logic [X_W-1:0]  VGA_X,
    output logic [Y_W-1:0]  VGA_Y,
    output logic [C_W-1:0]  VGA_COLOR,
    output logic            plot,
    output logic            busy,
    output logic            done
);

    localparam logic [X_W:0] X_LIM = (X_W+1)'(SCR_W);
    localparam logic [Y_W:0] Y_LIM = (Y_W+1)'(SCR_H);

    state_t          state;
    logic [X_W-1:0]  x_q;
    logic [Y_W-1:0]  y_q;
    logic [SZ_W-1:0] w_q;
    logic [SZ_W-1:0] h_q;
    logic [C_W-1:0]  color_q;
    logic [1:0]      mode_q;

    logic            accept;
    logic [X_W-1:0]  x_src;
    logic [Y_W-1:0]  y_src;
    logic [SZ_W-1:0] w_src;
    logic [SZ_W-1:0] h_src;
    logic [C_W-1:0]  color_src;
    logic [1:0]      mode_src;
    logic [SZ_W-1:0] tgt_cx;
    logic [SZ_W-1:0] tgt_cy;
    logic            at_left, at_right, at_top, at_bottom, last;
    logic [X_W:0]    sum_x;
    logic [Y_W:0]    sum_y;
    logic            zero_size;
    logic            load_px;
    logic            emit;

    assign accept    = (state == ST_IDLE) && req_valid;
    assign req_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign zero_size = (req_w == '0) || (req_h == '0);

    // Output registers run one offset ahead of the counter, so on the accept
    // edge the geometry comes straight from the request rather than the latches.
    assign x_src     = accept ? req_x    : x_q;
    assign y_src     = accept ? req_y    : y_q;
    assign w_src     = accept ? req_w    : w_q;
    assign h_src     = accept ? req_h    : h_q;
    assign mode_src  = accept ? req_mode : mode_q;
    assign color_src = accept ? ((req_mode == MODE_CLEAR) ? '0 : req_color) : color_q;

    rect_scan_counter #(.SZ_W(SZ_W)) u_scan (
        .clk       (CLOCK_50),
        .rst       (Reset),
        .clear     (accept),
        .step      ((state == ST_SCAN) && !last),
        .w         (w_src),
        .h         (h_src),
        .tgt_cx    (tgt_cx),
        .tgt_cy    (tgt_cy),
        .at_left   (at_left),
        .at_right  (at_right),
        .at_top    (at_top),
        .at_bottom (at_bottom),
        .last      (last)
    );

    // Widened sums so a rectangle running off the right/bottom never wraps on-screen.
    assign sum_x   = {1'b0, x_src} + (X_W+1)'(tgt_cx);
    assign sum_y   = {1'b0, y_src} + (Y_W+1)'(tgt_cy);
    assign load_px = accept ? !zero_size : ((state == ST_SCAN) && !last);
    assign emit    = load_px && (sum_x < X_LIM) && (sum_y < Y_LIM) &&
                     ((mode_src != MODE_OUTLINE) || at_left || at_right || at_top || at_bottom);

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            state     <= ST_IDLE;
            plot      <= 1'b0;
            VGA_X     <= '0;
            VGA_Y     <= '0;
            VGA_COLOR <= '0;
            x_q       <= '0;
            y_q       <= '0;
            w_q       <= '0;
            h_q       <= '0;
            color_q   <= '0;
            mode_q    <= MODE_FILL;
        end else begin
            case (state)
                ST_IDLE: if (accept) state <= zero_size ? ST_DONE : ST_SCAN;
                ST_SCAN: if (last)   state <= ST_DONE;
                default:             state <= ST_IDLE;
            endcase

            if (accept) begin
                x_q     <= req_x;
                y_q     <= req_y;
                w_q     <= req_w;
                h_q     <= req_h;
                mode_q  <= req_mode;
                color_q <= color_src;
            end

            plot <= emit;
            if (emit) begin
                VGA_X     <= sum_x[X_W-1:0];
                VGA_Y     <= sum_y[Y_W-1:0];
                VGA_COLOR <= color_src;
            end
        end
    end

endmodule

// File: tb/tb_rect_plotter.sv
// Directed self-checking bench for rect_plotter: fill, outline, clipping, clear,
// zero size, mode 11, mid-command reset and requests made while busy.
module tb_rect_plotter;

    logic       CLOCK_50 = 1'b0;
    logic       Reset;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_x;
    logic [6:0] req_y;
    logic [4:0] req_w;
    logic [4:0] req_h;
    logic [2:0] req_color;
    logic [1:0] req_mode;
    logic [7:0] VGA_X;
    logic [6:0] VGA_Y;
    logic [2:0] VGA_COLOR;
    logic       plot;
    logic       busy;
    logic       done;

    int n_cmp  = 0;
    int n_fail = 0;
    int last_x = 0;
    int last_y = 0;
    int last_c = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    rect_plotter dut (
        .CLOCK_50  (CLOCK_50),
        .Reset     (Reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_w     (req_w),
        .req_h     (req_h),
        .req_color (req_color),
        .req_mode  (req_mode),
        .VGA_X     (VGA_X),
        .VGA_Y     (VGA_Y),
        .VGA_COLOR (VGA_COLOR),
        .plot      (plot),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    // Issues one command, then walks its scan cycle by cycle against the expected
    // pixel pattern; optionally keeps req_valid asserted with junk while busy.
    task automatic run_cmd(input string name, input int x, input int y, input int w, input int h,
                           input int c, input int m, input bit hold_valid, output int nplots);
        int  ec;
        int  ex;
        int  ey;
        bit  ep;
        nplots    = 0;
        req_x     = x[7:0];
        req_y     = y[6:0];
        req_w     = w[4:0];
        req_h     = h[4:0];
        req_color = c[2:0];
        req_mode  = m[1:0];
        req_valid = 1'b1;
        step();
        if (hold_valid) begin
            req_x     = 8'd1;
            req_y     = 7'd1;
            req_w     = 5'd1;
            req_h     = 5'd1;
            req_color = 3'd6;
            req_mode  = 2'd0;
        end else begin
            req_valid = 1'b0;
        end
        ec = (m == 2) ? 0 : c;
        for (int n = 0; n < w * h; n++) begin
            int cx;
            int cy;
            cx = n % w;
            cy = n / w;
            ex = x + cx;
            ey = y + cy;
            ep = (ex < 160) && (ey < 120) &&
                 ((m != 1) || (cx == 0) || (cx == w - 1) || (cy == 0) || (cy == h - 1));
            check($sformatf("%s plot n=%0d", name, n), plot, ep);
            if (ep) begin
                nplots++;
                last_x = ex;
                last_y = ey;
                last_c = ec;
            end
            check($sformatf("%s x n=%0d", name, n), VGA_X, last_x);
            check($sformatf("%s y n=%0d", name, n), VGA_Y, last_y);
            check($sformatf("%s color n=%0d", name, n), VGA_COLOR, last_c);
            check($sformatf("%s ready n=%0d", name, n), req_ready, 0);
            check($sformatf("%s busy n=%0d", name, n), busy, 1);
            check($sformatf("%s early done n=%0d", name, n), done, 0);
            step();
        end
        req_valid = 1'b0;
        check({name, " done pulse"}, done, 1);
        check({name, " plot in done"}, plot, 0);
        check({name, " ready in done"}, req_ready, 0);
        check({name, " busy in done"}, busy, 1);
        step();
        check({name, " done cleared"}, done, 0);
        check({name, " ready back"}, req_ready, 1);
        check({name, " busy cleared"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int np;
        int n_done;
        int n_plot;

        Reset     = 1'b1;
        req_valid = 1'b0;
        req_x     = '0;
        req_y     = '0;
        req_w     = '0;
        req_h     = '0;
        req_color = '0;
        req_mode  = '0;
        step();
        step();
        Reset = 1'b0;
        step();

        check("reset plot", plot, 0);
        check("reset x", VGA_X, 0);
        check("reset y", VGA_Y, 0);
        check("reset color", VGA_COLOR, 0);
        check("reset done", done, 0);
        check("reset busy", busy, 0);
        check("reset ready", req_ready, 1);

        run_cmd("fill", 10, 20, 3, 2, 5, 0, 1'b0, np);
        check("fill pixel count", np, 6);

        run_cmd("outline", 0, 0, 4, 3, 2, 1, 1'b0, np);
        check("outline pixel count", np, 10);

        run_cmd("clip", 158, 119, 4, 2, 3, 0, 1'b0, np);
        check("clip pixel count", np, 2);

        run_cmd("clear", 5, 6, 2, 1, 7, 2, 1'b0, np);
        check("clear pixel count", np, 2);

        run_cmd("zero", 40, 40, 0, 5, 4, 0, 1'b0, np);
        check("zero pixel count", np, 0);

        run_cmd("mode3 edge", 159, 0, 1, 1, 5, 3, 1'b0, np);
        check("mode3 edge pixel count", np, 1);

        run_cmd("nowrap", 254, 0, 4, 1, 5, 3, 1'b0, np);
        check("nowrap pixel count", np, 0);

        // Reset lands while the third pixel of a 4x4 fill is on the outputs.
        req_x     = 8'd30;
        req_y     = 7'd40;
        req_w     = 5'd4;
        req_h     = 5'd4;
        req_color = 3'd1;
        req_mode  = 2'd0;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("pre-reset plot %0d", i), plot, 1);
            check($sformatf("pre-reset x %0d", i), VGA_X, 30 + i);
            check($sformatf("pre-reset y %0d", i), VGA_Y, 40);
            if (i < 2) step();
        end
        Reset = 1'b1;
        step();
        Reset  = 1'b0;
        last_x = 0;
        last_y = 0;
        last_c = 0;
        check("abort plot", plot, 0);
        check("abort done", done, 0);
        check("abort ready", req_ready, 1);
        check("abort busy", busy, 0);
        check("abort x", VGA_X, 0);
        n_done = 0;
        n_plot = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done) n_done++;
            if (plot) n_plot++;
        end
        check("abort later done count", n_done, 0);
        check("abort later plot count", n_plot, 0);

        run_cmd("busy req", 50, 60, 2, 2, 4, 0, 1'b1, np);
        check("busy req pixel count", np, 4);
        n_done = 0;
        n_plot = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done) n_done++;
            if (plot) n_plot++;
        end
        check("busy req extra done", n_done, 0);
        check("busy req extra plot", n_plot, 0);
        check("busy req idle ready", req_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
